// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port and a data port share one RAM
// through an IDLE/ACCESS/RELEASE handshake. Data normally wins, but a
// pending fetch is forced through after DSTREAK consecutive data grants.
// Illegal sizes and misaligned addresses are rejected without touching the
// RAM. A missing MOC is bounded by TIMEOUT cycles.
module mem_arbiter #(
  parameter int TIMEOUT = 15,
  parameter int DSTREAK = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic        d_signed,
  input  logic [7:0]  d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_err,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_rdata,
  input  logic        mem_moc,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(DSTREAK + 2);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_MAX  = SW'(DSTREAK);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RELEASE} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [SW-1:0] streak;
  logic          is_fetch;
  logic          lat_signed;

  logic          grant_f;
  logic          grant_d;
  logic          illegal;
  logic          sel_rw;
  logic [7:0]    sel_addr;
  logic [1:0]    sel_size;
  logic [31:0]   ext_rdata;

  // Arbitration and legality check of the port that would be granted now.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant_f  = if_req && (!d_req || streak == S_MAX);
    grant_d  = d_req && !grant_f;
    sel_rw   = 1'b1;
    sel_addr = if_addr;
    sel_size = 2'b10;
    illegal  = (if_addr[1:0] != 2'b00);
    if (!grant_f) begin
      sel_rw   = d_rw;
      sel_addr = d_addr;
      sel_size = d_size;
      illegal  = (d_size == 2'b11)
              || (d_size == 2'b01 && d_addr[0])
              || (d_size == 2'b10 && d_addr[1:0] != 2'b00);
    end
  end

  // Sign/zero extension of the RAM read word according to the latched size.
  always_comb begin
    ext_rdata = mem_rdata;
    case (mem_size)
      2'b00:   ext_rdata = {{24{lat_signed & mem_rdata[7]}},  mem_rdata[7:0]};
      2'b01:   ext_rdata = {{16{lat_signed & mem_rdata[15]}}, mem_rdata[15:0]};
      default: ext_rdata = mem_rdata;
    endcase
  end

  // Single FSM register block; every output is a register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      streak     <= '0;
      is_fetch   <= 1'b0;
      lat_signed <= 1'b0;
      if_rdata   <= '0;
      if_done    <= 1'b0;
      if_err     <= 1'b0;
      d_rdata    <= '0;
      d_done     <= 1'b0;
      d_err      <= 1'b0;
      mem_enable <= 1'b0;
      mem_rw     <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_size   <= 2'b00;
      busy       <= 1'b0;
    end else begin
      // Streak counts data grants that overtook a waiting fetch.
      if (!if_req)
        streak <= '0;
      else if (state == S_IDLE && grant_f)
        streak <= '0;
      else if (state == S_IDLE && grant_d && streak != S_MAX)
        streak <= streak + 1'b1;

      case (state)
        S_IDLE: begin
          if (grant_d || grant_f) begin
            busy       <= 1'b1;
            is_fetch   <= grant_f;
            lat_signed <= grant_d & d_signed;
            wait_cnt   <= '0;
            if (illegal) begin
              // Rejected request completes without a RAM cycle.
              state <= S_RELEASE;
              if (grant_f) begin
                if_done  <= 1'b1;
                if_err   <= 1'b1;
                if_rdata <= '0;
              end else begin
                d_done  <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end
            end else begin
              state      <= S_ACCESS;
              mem_enable <= 1'b1;
              mem_rw     <= sel_rw;
              mem_addr   <= sel_addr;
              mem_size   <= sel_size;
              if (grant_d) mem_wdata <= d_wdata;
            end
          end
        end

        S_ACCESS: begin
          if (mem_moc || wait_cnt == T_LAST) begin
            // MOC wins over a timeout landing on the same edge.
            mem_enable <= 1'b0;
            state      <= S_RELEASE;
            if (is_fetch) begin
              if_done  <= 1'b1;
              if_err   <= !mem_moc;
              if_rdata <= mem_moc ? ext_rdata : '0;
            end else begin
              d_done <= 1'b1;
              d_err  <= !mem_moc;
              if (mem_rw || !mem_moc) d_rdata <= mem_moc ? ext_rdata : '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RELEASE: begin
          if_done <= 1'b0;
          if_err  <= 1'b0;
          d_done  <= 1'b0;
          d_err   <= 1'b0;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a byte-array RAM with programmable
// MOC delay, a transaction-level model predicting each completion, and a
// per-cycle compare process.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;
  localparam int DSTREAK = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done, if_err;
  logic        d_req = 1'b0, d_rw = 1'b1, d_signed = 1'b0;
  logic [1:0]  d_size = 2'b10;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic        mem_enable, mem_rw, mem_moc, busy;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_size;

  mem_arbiter #(.TIMEOUT(TIMEOUT), .DSTREAK(DSTREAK)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .if_err(if_err),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_signed(d_signed),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_done(d_done), .d_err(d_err),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(mem_rdata),
    .mem_moc(mem_moc), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: little-endian bytes, MOC after moc_delay enabled edges.
  logic [7:0] ram [256];
  logic [7:0] ref_mem [256];
  int moc_delay = 0;
  int en_cnt = 0;

  assign mem_rdata = {ram[mem_addr + 8'd3], ram[mem_addr + 8'd2],
                      ram[mem_addr + 8'd1], ram[mem_addr]};
  assign mem_moc   = mem_enable && (en_cnt >= moc_delay);

  always @(posedge clk) begin
    if (!mem_enable) en_cnt <= 0;
    else             en_cnt <= en_cnt + 1;
    if (mem_enable && mem_moc && !mem_rw) begin
      ram[mem_addr] <= mem_wdata[7:0];
      if (mem_size != 2'b00) ram[mem_addr + 8'd1] <= mem_wdata[15:8];
      if (mem_size == 2'b10) begin
        ram[mem_addr + 8'd2] <= mem_wdata[23:16];
        ram[mem_addr + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Transaction-level model.
  typedef struct {
    bit          fetch;
    bit          err;
    logic [31:0] rdata;
    int          en_cycles;
    bit          rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] last_d = '0;
  logic [31:0] last_f = '0;

  function automatic exp_t predict(input bit f, input bit rw, input logic [1:0] sz,
                                   input bit sg, input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    int v;
    bit bad;
    logic [31:0] raw;
    e.fetch = f;
    e.rw    = f ? 1'b1 : rw;
    e.size  = f ? 2'b10 : sz;
    e.addr  = a;
    e.wdata = wd;
    if (e.size == 2'b11)      bad = 1'b1;
    else if (e.size == 2'b01) bad = (a % 2) != 0;
    else if (e.size == 2'b10) bad = (a % 4) != 0;
    else                      bad = 1'b0;
    if (bad)                    e.en_cycles = 0;
    else if (moc_delay < TIMEOUT) e.en_cycles = moc_delay + 1;
    else                        e.en_cycles = TIMEOUT;
    e.err = bad || (moc_delay >= TIMEOUT);
    if (e.err) begin
      e.rdata = '0;
    end else if (e.rw) begin
      raw = {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
      if (e.size == 2'b00) begin
        v = int'(raw[7:0]);
        if (sg && v > 127) v -= 256;
        e.rdata = 32'(v);
      end else if (e.size == 2'b01) begin
        v = int'(raw[15:0]);
        if (sg && v > 32767) v -= 65536;
        e.rdata = 32'(v);
      end else begin
        e.rdata = raw;
      end
    end else begin
      for (int i = 0; i < (1 << e.size); i++) ref_mem[a + 8'(i)] = wd[8*i +: 8];
      e.rdata = last_d;
    end
    if (f) last_f = e.rdata;
    else   last_d = e.rdata;
    return e;
  endfunction

  // Per-cycle compare against the model and structural invariants.
  int          en_run = 0;
  bit          prev_en = 1'b0;
  logic [10:0] prev_ctl = '0;
  logic [31:0] prev_wd = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      en_run  = 0;
      prev_en = 1'b0;
    end else begin
      check("err_without_done", {30'd0, d_err & ~d_done, if_err & ~if_done}, 32'd0);
      check("busy_vs_state", {31'd0, busy}, {31'd0, mem_enable | d_done | if_done});
      check("single_done", {31'd0, d_done & if_done}, 32'd0);
      if (mem_enable && prev_en) begin
        check("mem_ctl_stable", {21'd0, mem_rw, mem_size, mem_addr}, {21'd0, prev_ctl});
        check("mem_wdata_stable", mem_wdata, prev_wd);
      end
      if (mem_enable && !prev_en) begin
        check("enable_has_expect", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check("mem_addr", {24'd0, mem_addr}, {24'd0, exp_q[0].addr});
          check("mem_rw_size", {29'd0, mem_rw, mem_size}, {29'd0, exp_q[0].rw, exp_q[0].size});
          if (!exp_q[0].rw) check("mem_wdata", mem_wdata, exp_q[0].wdata);
        end
      end
      if (mem_enable) en_run++;
      if (d_done || if_done) begin
        check("done_has_expect", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("done_port", {31'd0, if_done}, {31'd0, e.fetch});
          check("done_err", {31'd0, e.fetch ? if_err : d_err}, {31'd0, e.err});
          check("done_rdata", e.fetch ? if_rdata : d_rdata, e.rdata);
          check("enable_cycles", 32'(en_run), 32'(e.en_cycles));
        end
        en_run = 0;
      end
      prev_en  = mem_enable;
      prev_ctl = {mem_rw, mem_size, mem_addr};
      prev_wd  = mem_wdata;
    end
  end

  // One transaction on either port; returns latency in cycles from the
  // sampling edge, the DUT result and the model's prediction.
  task automatic run(input bit f, input bit rw, input logic [1:0] sz, input bit sg,
                     input logic [7:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output bit er,
                     output logic [31:0] pr);
    exp_t e;
    e = predict(f, rw, sz, sg, a, wd);
    pr = e.rdata;
    exp_q.push_back(e);
    if (f) begin
      if_addr = a;
      if_req  = 1'b1;
    end else begin
      d_rw = rw; d_size = sz; d_signed = sg; d_addr = a; d_wdata = wd;
      d_req = 1'b1;
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(f ? if_done : d_done) && lat < 100);
    check("done_within_bound", {31'd0, f ? if_done : d_done}, 32'd1);
    rd = f ? if_rdata : d_rdata;
    er = f ? if_err : d_err;
    if_req = 1'b0;
    d_req  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] rd, pr;
    bit er;
    bit [7:0] model_bits, act_bits;
    int s, n, cyc, first_done, gap;
    exp_t ab;

    for (int i = 0; i < 256; i++) begin
      ram[i]     = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ram[10] = 8'hFE;
    ref_mem[10] = 8'hFE;

    // Reset values
    #1 rst_n = 1'b0;
    #2;
    check("rst_enable", {31'd0, mem_enable}, 32'd0);
    check("rst_rw", {31'd0, mem_rw}, 32'd1);
    check("rst_addr_size", {22'd0, mem_addr, mem_size}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_done_err", {28'd0, d_done, d_err, if_done, if_err}, 32'd0);
    check("rst_rdata", d_rdata | if_rdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Word write then read back
    run(1'b0, 1'b0, 2'b10, 1'b0, 8'd0, 32'hA00000AB, lat, rd, er, pr);
    check("wr_latency", 32'(lat), 32'd2);
    check("wr_err", {31'd0, er}, 32'd0);
    run(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("rd_word", rd, 32'hA00000AB);
    check("pin_model_word", pr, 32'hA00000AB);
    check("rd_latency", 32'(lat), 32'd2);

    // Byte reads, signed and unsigned
    run(1'b0, 1'b1, 2'b00, 1'b1, 8'd10, 32'h0, lat, rd, er, pr);
    check("rd_byte_signed", rd, 32'hFFFFFFFE);
    check("pin_model_byte", pr, 32'hFFFFFFFE);
    run(1'b0, 1'b1, 2'b00, 1'b0, 8'd10, 32'h0, lat, rd, er, pr);
    check("rd_byte_unsigned", rd, 32'h000000FE);

    // Halfword write and extension; byte write merges into it
    run(1'b0, 1'b0, 2'b01, 1'b0, 8'd20, 32'hDEAD8123, lat, rd, er, pr);
    check("wr_holds_rdata", rd, 32'h000000FE);
    run(1'b0, 1'b1, 2'b01, 1'b1, 8'd20, 32'h0, lat, rd, er, pr);
    check("rd_half_signed", rd, 32'hFFFF8123);
    run(1'b0, 1'b0, 2'b00, 1'b0, 8'd21, 32'h12345677, lat, rd, er, pr);
    run(1'b0, 1'b1, 2'b01, 1'b0, 8'd20, 32'h0, lat, rd, er, pr);
    check("rd_half_merged", rd, 32'h00007723);

    // Illegal requests finish in one cycle without a RAM cycle
    run(1'b0, 1'b1, 2'b01, 1'b0, 8'd9, 32'h0, lat, rd, er, pr);
    check("half_misaligned_err", {31'd0, er}, 32'd1);
    check("half_misaligned_lat", 32'(lat), 32'd1);
    run(1'b0, 1'b1, 2'b11, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("size11_err", {31'd0, er}, 32'd1);
    check("size11_rdata", rd, 32'd0);
    run(1'b0, 1'b0, 2'b10, 1'b0, 8'd2, 32'h55555555, lat, rd, er, pr);
    check("word_misaligned_err", {31'd0, er}, 32'd1);

    // Fetch port
    run(1'b1, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("fetch_word", rd, 32'hA00000AB);
    run(1'b1, 1'b1, 2'b10, 1'b0, 8'd2, 32'h0, lat, rd, er, pr);
    check("fetch_misaligned_err", {31'd0, er}, 32'd1);
    check("fetch_misaligned_lat", 32'(lat), 32'd1);

    // Slow MOC, last-chance MOC, and timeout
    moc_delay = 3;
    run(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("slow_moc_lat", 32'(lat), 32'd5);
    check("slow_moc_rdata", rd, 32'hA00000AB);
    moc_delay = TIMEOUT - 1;
    run(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("edge_moc_err", {31'd0, er}, 32'd0);
    check("edge_moc_lat", 32'(lat), 32'(TIMEOUT + 1));
    moc_delay = 255;
    run(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("timeout_err", {31'd0, er}, 32'd1);
    check("timeout_rdata", rd, 32'd0);
    check("timeout_lat", 32'(lat), 32'(TIMEOUT + 1));
    run(1'b0, 1'b0, 2'b10, 1'b0, 8'd4, 32'hCAFEF00D, lat, rd, er, pr);
    run(1'b1, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("fetch_timeout_rdata", rd, 32'd0);
    moc_delay = 0;
    run(1'b0, 1'b1, 2'b10, 1'b0, 8'd4, 32'h0, lat, rd, er, pr);

    // Both ports held: data streaks are capped so fetch gets its turn
    model_bits = '0;
    s = 0;
    for (int k = 0; k < 8; k++) begin
      if (s == DSTREAK) begin
        model_bits[k] = 1'b1;
        s = 0;
      end else if (s < DSTREAK) begin
        s++;
      end
    end
    check("pin_model_order", {24'd0, model_bits}, 32'h88);
    for (int k = 0; k < 8; k++)
      exp_q.push_back(predict(model_bits[k], 1'b1, 2'b10, 1'b0, model_bits[k] ? 8'd8 : 8'd4, 32'h0));
    d_rw = 1'b1; d_size = 2'b10; d_signed = 1'b0; d_addr = 8'd4;
    if_addr = 8'd8;
    d_req = 1'b1;
    if_req = 1'b1;
    act_bits = '0;
    n = 0;
    cyc = 0;
    first_done = 0;
    gap = 0;
    while (n < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (d_done || if_done) begin
        act_bits[n] = if_done;
        if (n == 0) first_done = cyc;
        if (n == 1) gap = cyc - first_done;
        n++;
      end
    end
    d_req = 1'b0;
    if_req = 1'b0;
    check("held_all_done", 32'(n), 32'd8);
    check("held_grant_order", {24'd0, act_bits}, 32'h88);
    check("back_to_back_gap", 32'(gap), 32'd3);
    @(negedge clk);

    // Reset in the middle of an access
    moc_delay = 255;
    ab.fetch = 1'b0; ab.err = 1'b0; ab.rdata = '0; ab.en_cycles = 0;
    ab.rw = 1'b1; ab.size = 2'b10; ab.addr = 8'd0; ab.wdata = '0;
    exp_q.push_back(ab);
    d_rw = 1'b1; d_size = 2'b10; d_addr = 8'd0;
    d_req = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_enable_before", {31'd0, mem_enable}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_enable_drop", {31'd0, mem_enable}, 32'd0);
    check("abort_busy_drop", {31'd0, busy}, 32'd0);
    check("abort_rdata_clear", d_rdata, 32'd0);
    exp_q.delete();
    last_d = '0;
    last_f = '0;
    d_req = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_done_after_reset", {30'd0, d_done, if_done}, 32'd0);
    end
    moc_delay = 0;
    run(1'b0, 1'b1, 2'b10, 1'b0, 8'd0, 32'h0, lat, rd, er, pr);
    check("after_reset_rdata", rd, 32'hA00000AB);
    check("after_reset_lat", 32'(lat), 32'd2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
